// File: rtl/ad_trig_capture.sv
// Edge-triggered capture of the AD sample stream into a circular buffer, with a frozen pre/post frame.
// Optional AUTO_TRIG_EN: force a trigger after AUTO_TIMEOUT samples without an edge.
module ad_trig_capture #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 10,
  parameter int PRE_TRIG     = 256,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              arm,
  input  logic [DATA_W-1:0] ad_data_in,
  input  logic [15:0]       sample_div,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  output logic              sample_stb,
  output logic              frame_ready,
  output logic              trig_hit,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_done
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int POST_LEN = DEPTH - PRE_TRIG;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_READY = 3'd4;

  localparam logic [ADDR_W-1:0] PRE_OFS  = ADDR_W'(PRE_TRIG);
  localparam logic [8:0]        FILL_MAX = 9'(PRE_TRIG);
  localparam logic [ADDR_W:0]   POST_MAX = (ADDR_W+1)'(POST_LEN);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [2:0]        state_q, state_d;
  logic [15:0]       div_q, div_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [8:0]        fill_q, fill_d;
  logic [ADDR_W:0]   post_q, post_d;
  logic [ADDR_W-1:0] trig_ptr_q, trig_ptr_d;
  logic              trig_hit_q, trig_hit_d;
  logic              frame_ready_q, frame_ready_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              active;
  logic              sample;
  logic              hit_now;
  logic              force_now;
  logic [ADDR_W-1:0] rd_idx;

`ifdef AUTO_TRIG_EN
  localparam int               AUTO_W   = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [AUTO_W-1:0] AUTO_MAX = AUTO_W'(AUTO_TIMEOUT);
  logic [AUTO_W-1:0] auto_q, auto_d;
  assign force_now = (auto_q == AUTO_MAX);
`else
  assign force_now = 1'b0;
`endif

  assign active  = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign sample  = active && (div_q == '0);
  // A crossing needs the previous sample on the far side of the level, so a flat input never fires.
  assign hit_now = trig_slope ? ((prev_q > trig_level) && (ad_data_in <= trig_level))
                              : ((prev_q < trig_level) && (ad_data_in >= trig_level));
  assign rd_idx  = trig_ptr_q - PRE_OFS + rd_addr;

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    wr_ptr_d      = wr_ptr_q;
    prev_d        = prev_q;
    fill_d        = fill_q;
    post_d        = post_q;
    trig_ptr_d    = trig_ptr_q;
    trig_hit_d    = trig_hit_q;
    frame_ready_d = frame_ready_q;
`ifdef AUTO_TRIG_EN
    auto_d        = auto_q;
`endif
    rd_data_d     = mem[rd_idx];

    if (state_q == S_IDLE) begin
      div_d = '0;
    end else if (active) begin
      div_d = sample ? sample_div : div_q - 16'd1;
    end

    if (sample) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      prev_d   = ad_data_in;
      if (fill_q < FILL_MAX) fill_d = fill_q + 9'd1;
    end

    case (state_q)
      S_PRE: begin
        if (sample && (fill_d == FILL_MAX)) begin
          state_d = S_WAIT;
`ifdef AUTO_TRIG_EN
          auto_d  = '0;
`endif
        end
      end
      S_WAIT: begin
        if (sample) begin
          if (hit_now || force_now) begin
            trig_ptr_d    = wr_ptr_q;
            trig_hit_d    = hit_now;
            post_d        = (ADDR_W+1)'(1);
            state_d       = (POST_LEN == 1) ? S_READY : S_POST;
            frame_ready_d = (POST_LEN == 1);
          end
`ifdef AUTO_TRIG_EN
          else begin
            auto_d = auto_q + AUTO_W'(1);
          end
`endif
        end
      end
      S_POST: begin
        if (sample) begin
          post_d = post_q + (ADDR_W+1)'(1);
          if (post_d == POST_MAX) begin
            state_d       = S_READY;
            frame_ready_d = 1'b1;
          end
        end
      end
      S_READY: begin
        if (rd_done) begin
          state_d       = S_IDLE;
          frame_ready_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // arm outranks rd_done; en low outranks everything.
    if (arm) begin
      state_d       = S_PRE;
      fill_d        = '0;
      frame_ready_d = 1'b0;
      trig_hit_d    = 1'b0;
    end
    if (!en) begin
      state_d       = S_IDLE;
      frame_ready_d = 1'b0;
      trig_hit_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sample) mem[wr_ptr_q] <= ad_data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      div_q         <= '0;
      wr_ptr_q      <= '0;
      prev_q        <= '0;
      fill_q        <= '0;
      post_q        <= '0;
      trig_ptr_q    <= '0;
      trig_hit_q    <= 1'b0;
      frame_ready_q <= 1'b0;
      rd_data_q     <= '0;
`ifdef AUTO_TRIG_EN
      auto_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      wr_ptr_q      <= wr_ptr_d;
      prev_q        <= prev_d;
      fill_q        <= fill_d;
      post_q        <= post_d;
      trig_ptr_q    <= trig_ptr_d;
      trig_hit_q    <= trig_hit_d;
      frame_ready_q <= frame_ready_d;
      rd_data_q     <= rd_data_d;
`ifdef AUTO_TRIG_EN
      auto_q        <= auto_d;
`endif
    end
  end

  assign sample_stb  = sample;
  assign frame_ready = frame_ready_q;
  assign trig_hit    = trig_hit_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_ad_trig_capture.sv
module tb_ad_trig_capture;

  logic        clk = 1'b0;
  logic        rst_n, en, arm, trig_slope, rd_done;
  logic [7:0]  ad_data_in, trig_level;
  logic [15:0] sample_div;
  logic [3:0]  rd_addr;
  logic        sample_stb, frame_ready, trig_hit;
  logic [7:0]  rd_data;

  always #5 clk = ~clk;

  ad_trig_capture #(
    .DATA_W(8),
    .ADDR_W(4),
    .PRE_TRIG(4),
    .AUTO_TIMEOUT(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .arm(arm),
    .ad_data_in(ad_data_in),
    .sample_div(sample_div),
    .trig_level(trig_level),
    .trig_slope(trig_slope),
    .sample_stb(sample_stb),
    .frame_ready(frame_ready),
    .trig_hit(trig_hit),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_done(rd_done)
  );

  int          checks = 0;
  int          failures = 0;
  int          stb_total = 0;
  logic [7:0]  vec [64];

  always @(negedge clk) begin
    if (sample_stb === 1'b1) stb_total = stb_total + 1;
  end

  task automatic report(input bit ok, input string n);
    checks = checks + 1;
    if (!ok) begin
      failures = failures + 1;
      $display("FAIL %s: frame_ready=%b trig_hit=%b sample_stb=%b rd_data=%0h",
               n, frame_ready, trig_hit, sample_stb, rd_data);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input logic [3:0] a, input logic [7:0] e, input string n);
    rd_addr = a;
    step();
    report(rd_data === e, n);
    @(negedge clk);
  endtask

  task automatic do_arm(input logic done);
    arm     = 1'b1;
    rd_done = done;
    @(negedge clk);
    arm     = 1'b0;
    rd_done = 1'b0;
  endtask

  task automatic fill_ramp(input logic [7:0] start, input int step_v);
    for (int i = 0; i < 64; i++) vec[i] = 8'(int'(start) + i * step_v);
  endtask

  task automatic run_vec(input int n, input logic stop);
    for (int i = 0; i < n; i++) begin
      ad_data_in = vec[i];
      @(negedge clk);
      if (stop && frame_ready) break;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int base;
    int last_c;
    rst_n = 1'b0; en = 1'b1; arm = 1'b0; rd_done = 1'b0;
    ad_data_in = 8'h00; trig_level = 8'h80; trig_slope = 1'b0;
    sample_div = 16'd0; rd_addr = 4'd0;
    repeat (2) @(negedge clk);
    step();
    report(frame_ready === 1'b0, "reset_frame_ready");
    report(trig_hit === 1'b0, "reset_trig_hit");
    report(sample_stb === 1'b0, "reset_sample_stb");
    report(rd_data === 8'h00, "reset_rd_data");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    fill_ramp(8'h70, 1);
    do_arm(1'b0);
    run_vec(60, 1'b1);
    step();
    report(frame_ready === 1'b1, "t1_frame_ready");
    @(negedge clk);
    step();
    report(trig_hit === 1'b1, "t1_trig_hit");
    @(negedge clk);
    read_chk(4'd4, 8'h80, "t1_rd4");
    read_chk(4'd0, 8'h7C, "t1_rd0");
    read_chk(4'd15, 8'h8B, "t1_rd15");
    rd_done = 1'b1;
    step();
    report(frame_ready === 1'b0, "t1_release_frame_ready");
    @(negedge clk);
    rd_done = 1'b0;
    step();
    report(sample_stb === 1'b0, "t1_idle_no_stb");
    @(negedge clk);

    trig_slope = 1'b1;
    fill_ramp(8'h90, -1);
    do_arm(1'b0);
    run_vec(60, 1'b1);
    step();
    report(frame_ready === 1'b1, "t2_frame_ready");
    @(negedge clk);
    step();
    report(trig_hit === 1'b1, "t2_trig_hit");
    @(negedge clk);
    read_chk(4'd4, 8'h80, "t2_rd4");
    read_chk(4'd3, 8'h81, "t2_rd3");
    read_chk(4'd0, 8'h84, "t2_rd0");
    read_chk(4'd15, 8'h75, "t2_rd15");

    trig_slope = 1'b0;
    vec[0] = 8'h7E; vec[1] = 8'h81; vec[2] = 8'h82; vec[3] = 8'h83;
    vec[4] = 8'h50; vec[5] = 8'h60; vec[6] = 8'h70; vec[7] = 8'h85;
    for (int i = 8; i < 64; i++) vec[i] = 8'(8'h86 + (i - 8));
    do_arm(1'b0);
    run_vec(60, 1'b1);
    step();
    report(frame_ready === 1'b1, "t4_frame_ready");
    @(negedge clk);
    step();
    report(trig_hit === 1'b1, "t4_trig_hit");
    @(negedge clk);
    read_chk(4'd0, 8'h83, "t4_rd0");
    read_chk(4'd3, 8'h70, "t4_rd3");
    read_chk(4'd4, 8'h85, "t4_rd4");
    read_chk(4'd15, 8'h90, "t4_rd15");
    do_arm(1'b0);
    run_vec(10, 1'b0);
    en = 1'b0;
    step();
    report(trig_hit === 1'b0, "t4_en_low_trig_hit");
    @(negedge clk);
    step();
    report(sample_stb === 1'b0, "t4_en_low_idle");
    @(negedge clk);
    step();
    report(frame_ready === 1'b0, "t4_en_low_frame_ready");
    @(negedge clk);
    en = 1'b1;

    fill_ramp(8'h70, 1);
    do_arm(1'b0);
    run_vec(60, 1'b1);
    step();
    report(frame_ready === 1'b1, "t5_frame_ready");
    @(negedge clk);
    do_arm(1'b1);
    step();
    report(frame_ready === 1'b0, "t5_arm_wins_frame_ready");
    @(negedge clk);
    step();
    report(sample_stb === 1'b1, "t5_arm_wins_in_pre");
    @(negedge clk);
    fill_ramp(8'h70, 1);
    run_vec(21, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    report(frame_ready === 1'b0, "t5_async_frame_ready");
    report(trig_hit === 1'b0, "t5_async_trig_hit");
    report(sample_stb === 1'b0, "t5_async_sample_stb");
    report(rd_data === 8'h00, "t5_async_rd_data");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    sample_div = 16'd3;
    ad_data_in = 8'h40;
    base = stb_total;
    do_arm(1'b0);
    k = 0;
    last_c = 0;
    for (int c = 0; c < 5000; c++) begin
      step();
      if (frame_ready) break;
      if (sample_stb) begin
        k++;
        if (k >= 2 && k <= 7) report((c - last_c) == 4, "t3_stb_gap");
        last_c = c;
`ifndef AUTO_TRIG_EN
        if (k >= 1000) break;
`endif
      end
    end
    @(negedge clk);
`ifdef AUTO_TRIG_EN
    report(frame_ready === 1'b1, "t3_auto_frame_ready");
    report(trig_hit === 1'b0, "t3_auto_trig_hit");
    report((stb_total - base) == 48, "t3_auto_strobes");
`else
    report(frame_ready === 1'b0, "t3_no_auto_frame_ready");
`endif
    en = 1'b0;
    step();
    report(frame_ready === 1'b0, "t3_en_low_frame_ready");
    @(negedge clk);
    step();
    report(sample_stb === 1'b0, "t3_en_low_idle");
    @(negedge clk);
    en = 1'b1;

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
